// File: rtl/mem_req_scheduler_if.sv
// Request/response bundle between the icache, the load/store buffer, the
// scheduler and the byte-serial memory controller.
interface mem_req_scheduler_if;
  logic        icReqIn;
  logic [31:0] icAddrIn;
  logic        icDoneOut;
  logic [31:0] icDataOut;
  logic        lsbReqIn;
  logic [2:0]  lsbOpIn;
  logic [31:0] lsbAddrIn;
  logic [31:0] lsbDataIn;
  logic        lsbDoneOut;
  logic [31:0] lsbDataOut;
  logic        mcIcacheFlagOut;
  logic [31:0] mcIcacheAddrOut;
  logic        mcLsbFlagOut;
  logic [2:0]  mcLsbOpOut;
  logic [31:0] mcLsbAddrOut;
  logic [31:0] mcLsbDataOut;
  logic        mcIcacheOkIn;
  logic        mcLsbOkIn;
  logic [31:0] mcDataIn;

  modport slave (
    input  icReqIn, icAddrIn, lsbReqIn, lsbOpIn, lsbAddrIn, lsbDataIn,
           mcIcacheOkIn, mcLsbOkIn, mcDataIn,
    output icDoneOut, icDataOut, lsbDoneOut, lsbDataOut,
           mcIcacheFlagOut, mcIcacheAddrOut, mcLsbFlagOut,
           mcLsbOpOut, mcLsbAddrOut, mcLsbDataOut
  );

  modport master (
    output icReqIn, icAddrIn, lsbReqIn, lsbOpIn, lsbAddrIn, lsbDataIn,
           mcIcacheOkIn, mcLsbOkIn, mcDataIn,
    input  icDoneOut, icDataOut, lsbDoneOut, lsbDataOut,
           mcIcacheFlagOut, mcIcacheAddrOut, mcLsbFlagOut,
           mcLsbOpOut, mcLsbAddrOut, mcLsbDataOut
  );
endinterface

// File: rtl/mem_req_scheduler.sv
// Single-owner arbiter for the memory controller: LSB first, with a forced
// fetch grant after STARVE_LIMIT consecutive LSB grants while a fetch waits.
module mem_req_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic            clockIn,
  input  logic            resetIn,
  input  logic            readyIn,
  input  logic            clearIn,
  mem_req_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IC  = 2'd1,
    GNT_LSB = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [CNT_W-1:0] streak_r, streak_s;
  logic [31:0] ic_addr_r, ic_addr_s;
  logic [2:0]  lsb_op_r, lsb_op_s;
  logic [31:0] lsb_addr_r, lsb_addr_s;
  logic [31:0] lsb_wdata_r, lsb_wdata_s;
  logic [31:0] ic_data_r, ic_data_s;
  logic [31:0] lsb_rdata_r, lsb_rdata_s;
  logic        ic_done_r, ic_done_s;
  logic        lsb_done_r, lsb_done_s;
  logic        fetch_starved_s;

  assign fetch_starved_s = bus.icReqIn && (streak_r >= CNT_W'(STARVE_LIMIT));

  // State and latch registers
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      state_r     <= IDLE;
      streak_r    <= '0;
      ic_addr_r   <= 32'h0;
      lsb_op_r    <= 3'b000;
      lsb_addr_r  <= 32'h0;
      lsb_wdata_r <= 32'h0;
      ic_data_r   <= 32'h0;
      lsb_rdata_r <= 32'h0;
      ic_done_r   <= 1'b0;
      lsb_done_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      streak_r    <= streak_s;
      ic_addr_r   <= ic_addr_s;
      lsb_op_r    <= lsb_op_s;
      lsb_addr_r  <= lsb_addr_s;
      lsb_wdata_r <= lsb_wdata_s;
      ic_data_r   <= ic_data_s;
      lsb_rdata_r <= lsb_rdata_s;
      ic_done_r   <= ic_done_s;
      lsb_done_r  <= lsb_done_s;
    end
  end

  // Arbitration, grant completion and mispredict handling
  always_comb begin
    state_s     = state_r;
    streak_s    = streak_r;
    ic_addr_s   = ic_addr_r;
    lsb_op_s    = lsb_op_r;
    lsb_addr_s  = lsb_addr_r;
    lsb_wdata_s = lsb_wdata_r;
    ic_data_s   = ic_data_r;
    lsb_rdata_s = lsb_rdata_r;
    ic_done_s   = ic_done_r;
    lsb_done_s  = lsb_done_r;
    if (readyIn) begin
      ic_done_s  = 1'b0;
      lsb_done_s = 1'b0;
      case (state_r)
        IDLE: begin
          if (clearIn) begin
            state_s = IDLE;
          end else if (bus.lsbReqIn && !fetch_starved_s) begin
            state_s     = GNT_LSB;
            lsb_op_s    = bus.lsbOpIn;
            lsb_addr_s  = bus.lsbAddrIn;
            lsb_wdata_s = bus.lsbDataIn;
            if (!bus.icReqIn) begin
              streak_s = '0;
            end else if (streak_r != {CNT_W{1'b1}}) begin
              streak_s = streak_r + CNT_W'(1);
            end else begin
              streak_s = streak_r;
            end
          end else if (bus.icReqIn) begin
            state_s   = GNT_IC;
            ic_addr_s = bus.icAddrIn;
            streak_s  = '0;
          end else begin
            state_s = IDLE;
          end
        end
        GNT_IC: begin
          if (clearIn) begin
            state_s = IDLE;
          end else if (bus.mcIcacheOkIn) begin
            ic_data_s = bus.mcDataIn;
            ic_done_s = 1'b1;
            state_s   = IDLE;
          end else begin
            state_s = GNT_IC;
          end
        end
        GNT_LSB: begin
          // A store already on its way to memory must never be aborted
          if (clearIn && !lsb_op_r[2]) begin
            state_s = IDLE;
          end else if (bus.mcLsbOkIn) begin
            if (!lsb_op_r[2]) begin
              lsb_rdata_s = bus.mcDataIn;
            end else begin
              lsb_rdata_s = lsb_rdata_r;
            end
            lsb_done_s = 1'b1;
            state_s    = IDLE;
          end else begin
            state_s = GNT_LSB;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Flags drop in the ok cycle so the controller does not re-accept
  assign bus.mcIcacheFlagOut = (state_r == GNT_IC)  && !bus.mcIcacheOkIn;
  assign bus.mcLsbFlagOut    = (state_r == GNT_LSB) && !bus.mcLsbOkIn;
  assign bus.mcIcacheAddrOut = ic_addr_r;
  assign bus.mcLsbOpOut      = lsb_op_r;
  assign bus.mcLsbAddrOut    = lsb_addr_r;
  assign bus.mcLsbDataOut    = lsb_wdata_r;
  assign bus.icDoneOut       = ic_done_r;
  assign bus.icDataOut       = ic_data_r;
  assign bus.lsbDoneOut      = lsb_done_r;
  assign bus.lsbDataOut      = lsb_rdata_r;

endmodule

// File: doc/mem_req_scheduler.md
Name: mem_req_scheduler

Overview:
- Arbitrates the single byte-serial memory controller between the instruction cache and the load/store buffer (LSB).
- Presents exactly one request at a time on the controller's icache/LSB request pins and holds the latched address, op and data stable until the controller's ok pulse.
- Gives the LSB priority, with a bounded-starvation guarantee for instruction fetch.
- Sits between the icache/LSB and the memory controller; handles branch-mispredict clear by dropping speculative traffic while never aborting stores.

Parameters:
- STARVE_LIMIT, 4: consecutive LSB grants allowed while a fetch waits, before one forced icache grant.
- CNT_W, 3: width of the streak counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clockIn  in  1  system clock
- resetIn  in  1  asynchronous reset, active-high
- readyIn  in  1  global stall; block frozen when 0
- clearIn  in  1  mispredict flush
- icReqIn  in  1  icache fetch request (level)
- icAddrIn  in  32  fetch address
- icDoneOut  out  1  fetch complete pulse
- icDataOut  out  32  fetched word
- lsbReqIn  in  1  LSB request (level)
- lsbOpIn  in  3  [2]=store, [1:0]=00 byte, 01 half, 11 word
- lsbAddrIn  in  32  access address
- lsbDataIn  in  32  store data
- lsbDoneOut  out  1  LSB access complete pulse
- lsbDataOut  out  32  load data, raw and not sign-extended
- mcIcacheFlagOut  out  1  controller fetch request
- mcIcacheAddrOut  out  32  latched fetch address
- mcLsbFlagOut  out  1  controller LSB request
- mcLsbOpOut  out  3  latched op
- mcLsbAddrOut  out  32  latched address
- mcLsbDataOut  out  32  latched store data
- mcIcacheOkIn  in  1  controller fetch done
- mcLsbOkIn  in  1  controller LSB done
- mcDataIn  in  32  controller data bus

Behaviour:
- Reset (async, resetIn=1):
  - state=IDLE; streak=0.
  - All latches and data outputs 0; all flags and done outputs 0.
- States:
  - IDLE, GNT_IC, GNT_LSB. State is registered.
  - mcIcacheFlagOut = (state==GNT_IC) & ~mcIcacheOkIn.
  - mcLsbFlagOut = (state==GNT_LSB) & ~mcLsbOkIn.
  - Both flags are never high together. The flag drops in the ok cycle, so the controller's IDLE does not re-accept the request.
- readyIn=0: no state, latch, counter or output change. Done pulses are held until the next ready cycle and then cleared.
- IDLE arbitration (readyIn=1, clearIn=0):
  - If lsbReqIn & ~(icReqIn & streak>=STARVE_LIMIT): latch op/addr/data, go to GNT_LSB. streak increments (saturating) if icReqIn=1, otherwise streak=0.
  - Else if icReqIn: latch addr, go to GNT_IC, streak=0.
  - Else stay in IDLE.
  - Grant becomes visible on the mc pins the cycle after the request is sampled.
- GNT_IC:
  - On mcIcacheOkIn: icDataOut<=mcDataIn, icDoneOut<=1 for exactly one cycle, state<=IDLE.
  - The IDLE entered here may grant a new request one cycle later. There is no back-to-back grant in the ok cycle.
- GNT_LSB:
  - On mcLsbOkIn: lsbDataOut<=mcDataIn for loads (unchanged for stores), lsbDoneOut<=1 for one cycle, state<=IDLE.
- clearIn=1 with readyIn=1:
  - IDLE: no grant this cycle.
  - GNT_IC, or GNT_LSB with a load: return to IDLE. No done pulse, even if ok is high the same cycle. Clear wins.
  - GNT_LSB with a store: ignored. The store continues; done is reported normally.
  - streak is unaffected by clear.
- Done outputs are registered: one cycle after the ok input, one cycle wide. Data outputs hold until the next corresponding done.
- Latched mc address/op/data are stable for the whole grant. Requester inputs may change freely after grant.
- Ok inputs arriving in a state that does not match them are ignored. Example: mcIcacheOkIn in GNT_LSB.

Test Plan:
- Fetch only: icReqIn=1, icAddrIn=0x1000; the controller returns 0x00A00093 → mcIcacheAddrOut=0x1000 stable throughout; one icDoneOut pulse with icDataOut=0x00A00093; flag low in the ok cycle.
- Simultaneous requests: icReqIn and lsbReqIn (load word 0x2000) both raised → LSB granted first; fetch granted on the second cycle after lsbDoneOut.
- Starvation: icReqIn held high while the LSB issues 6 back-to-back byte loads, STARVE_LIMIT=4 → grant order is L,L,L,L,IC,L,L; streak resets after the IC grant.
- Clear on load: load half at 0x3002 granted; clearIn pulses mid-access → state IDLE next cycle, lsbDoneOut never asserts, a new fetch is granted afterwards.
- Clear on store: store word 0xDEADBEEF at 0x30000 granted; clearIn pulses → flag and latched data stay stable until ok; lsbDoneOut pulses once.
- Stall and reset: readyIn=0 for 3 cycles mid-grant → all outputs frozen. Asserting resetIn asynchronously mid-grant → flags drop immediately, state IDLE.
